pmp_csr_file: RTL and testbench

- M-mode CSR storage and write logic for the physical memory protection registers, covering pmpcfg0-15 and pmpaddr0-63.
- Its outputs, PMPCFG_ARRAY_REGW and PMPADDR_ARRAY_REGW, drive the PMP checker directly.
- Enforces WARL legalisation and lock (L) semantics on every write.
- Supplies read data to the CSR read mux, and emits a one-cycle update pulse so the TLB and instruction fetch can flush stale permission state.

---
 rtl/pmp_csr_file_pkg.sv | 29 ++
 rtl/pmp_cfg_byte_wr.sv | 33 +++
 rtl/pmp_csr_file.sv | 133 +++++++++++++
 tb/tb_pmp_csr_file.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmp_csr_file_pkg.sv
// Shared PMP CSR definitions: A-field encodings, cfg byte bit positions,
// CSR base addresses and the cfg byte type.
package pmp_csr_file_pkg;

  typedef logic [7:0] cfg_t;

  typedef enum logic [1:0] {
    PMP_OFF   = 2'b00,
    PMP_TOR   = 2'b01,
    PMP_NA4   = 2'b10,
    PMP_NAPOT = 2'b11
  } pmp_a_e;

  localparam int CFG_L    = 7;
  localparam int CFG_A_HI = 4;
  localparam int CFG_A_LO = 3;
  localparam int CFG_X    = 2;
  localparam int CFG_W    = 1;
  localparam int CFG_R    = 0;

  localparam logic [11:0] PMPCFG0  = 12'h3A0;
  localparam logic [11:0] PMPADDR0 = 12'h3B0;

  // Extract the address-matching mode of a cfg byte.
  function automatic logic [1:0] cfg_a(input cfg_t c);
    return c[CFG_A_HI:CFG_A_LO];
  endfunction

endpackage

// File: rtl/pmp_cfg_byte_wr.sv
// Next-value logic for one PMP cfg byte: reserved bits cleared, W without R
// dropped, locked bytes frozen, and (with PMP_G_EN) NA4 writes rejected.
module pmp_cfg_byte_wr import pmp_csr_file_pkg::*; #(
  parameter int G = 0
) (
  input  cfg_t old_i,
  input  cfg_t new_i,
  input  logic we_i,
  input  logic lock_i,
  output cfg_t next_o
);

`ifdef PMP_G_EN
  localparam bit G_EN = 1'b1;
`else
  localparam bit G_EN = 1'b0;
`endif
  // NA4 is not representable once the grain exceeds 4 bytes.
  localparam bit KEEP_NA4 = G_EN && (G >= 1);

  cfg_t legal;

  // Legalise the incoming byte, then apply the write enable and lock.
  always_comb begin
    legal      = new_i;
    legal[6:5] = 2'b00;
    if (legal[CFG_W] && !legal[CFG_R]) legal[CFG_W] = 1'b0;
    if (KEEP_NA4 && (legal[CFG_A_HI:CFG_A_LO] == PMP_NA4))
      legal[CFG_A_HI:CFG_A_LO] = old_i[CFG_A_HI:CFG_A_LO];
    next_o = (we_i && !lock_i) ? legal : old_i;
  end

endmodule

// File: rtl/pmp_csr_file.sv
// PMP CSR file: pmpcfg0-15 / pmpaddr0-63 storage with WARL and lock rules,
// combinational read data and a one-cycle "PMP changed" pulse.
// Optional macro PMP_G_EN enables granularity (PMP_G) handling.
module pmp_csr_file import pmp_csr_file_pkg::*; #(
  parameter int  PMP_ENTRIES = 16,
  parameter int  XLEN        = 64,
  parameter int  PA_BITS     = 56,
  parameter int  PMP_G       = 2,
  localparam int NE          = (PMP_ENTRIES > 0) ? PMP_ENTRIES : 1,
  localparam int AW          = PA_BITS - 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  StallW,
  input  logic                  CSRWriteM,
  input  logic                  CSRReadM,
  input  logic [11:0]           CSRAdrM,
  input  logic [XLEN-1:0]       CSRWriteValM,
  output cfg_t [NE-1:0]         PMPCFG_ARRAY_REGW,
  output logic [NE-1:0][AW-1:0] PMPADDR_ARRAY_REGW,
  output logic [XLEN-1:0]       CSRPReadValM,
  output logic                  IllegalPMPAccessM,
  output logic                  PMPUpdatedM
);

  localparam int BPR = XLEN / 8;  // cfg bytes per pmpcfg register

  if (!(PMP_ENTRIES == 0 || PMP_ENTRIES == 16 || PMP_ENTRIES == 64) ||
      !(XLEN == 32 || XLEN == 64) || PMP_G < 0) begin : g_bad_param
    $error("pmp_csr_file: unsupported parameter combination");
  end

`ifdef PMP_G_EN
  localparam logic [AW-1:0] NAPOT_ONES =
    AW'((64'd1 << ((PMP_G >= 2) ? PMP_G - 1 : 0)) - 64'd1);
  localparam logic [AW-1:0] GRAIN_MASK = AW'((64'd1 << PMP_G) - 64'd1);
`endif

  cfg_t [NE-1:0]         cfg_q, cfg_d, cfg_nxt;
  logic [NE-1:0][AW-1:0] addr_q, addr_d, addr_nxt, addr_rd;
  logic                  upd_q, upd_d;
  logic                  cfg_hit, addr_hit, illegal, commit;
  logic [3:0]            cfg_n;
  logic [5:0]            addr_n;

  // Decode the CSR address; odd pmpcfg is illegal in RV64.
  always_comb begin
    cfg_hit  = (CSRAdrM[11:4] == PMPCFG0[11:4]);
    addr_hit = (CSRAdrM >= PMPADDR0) && (CSRAdrM <= 12'h3EF);
    cfg_n    = CSRAdrM[3:0];
    addr_n   = 6'(CSRAdrM - PMPADDR0);
    illegal  = (XLEN == 64) && cfg_hit && cfg_n[0] && (CSRReadM || CSRWriteM);
    commit   = CSRWriteM && !StallW && (cfg_hit || addr_hit) && !illegal;
  end

  for (genvar i = 0; i < NE; i++) begin : g_ent
    localparam bit EN      = (i < PMP_ENTRIES);
    localparam int CFG_REG = (i / BPR) * (BPR / 4);
    localparam int BYTE    = i % BPR;

    logic cfg_we, addr_we, tor_lock;

    assign cfg_we = EN && commit && cfg_hit && (cfg_n == 4'(CFG_REG));

    pmp_cfg_byte_wr #(.G(PMP_G)) u_wr (
      .old_i  (cfg_q[i]),
      .new_i  (CSRWriteValM[8*BYTE +: 8]),
      .we_i   (cfg_we),
      .lock_i (cfg_q[i][CFG_L]),
      .next_o (cfg_nxt[i])
    );

    // A locked TOR entry above also freezes this entry's address (its base).
    if (i < NE - 1) begin : g_tor
      assign tor_lock = cfg_q[i+1][CFG_L] && (cfg_a(cfg_q[i+1]) == PMP_TOR);
    end else begin : g_last
      assign tor_lock = 1'b0;
    end

    assign addr_we = EN && commit && addr_hit && (addr_n == 6'(i)) &&
                     !cfg_q[i][CFG_L] && !tor_lock;
    assign addr_nxt[i] = addr_we ? AW'(CSRWriteValM) : addr_q[i];

`ifdef PMP_G_EN
    // Read view only; the stored address keeps every written bit.
    assign addr_rd[i] =
      (cfg_a(cfg_q[i]) == PMP_NAPOT) ? (addr_q[i] | NAPOT_ONES) :
      ((cfg_a(cfg_q[i]) == PMP_OFF) || (cfg_a(cfg_q[i]) == PMP_TOR)) ?
        (addr_q[i] & ~GRAIN_MASK) : addr_q[i];
`else
    assign addr_rd[i] = addr_q[i];
`endif
  end

  // Collect next state and flag any stored-bit change for the update pulse.
  always_comb begin
    cfg_d  = cfg_nxt;
    addr_d = addr_nxt;
    upd_d  = (cfg_d != cfg_q) || (addr_d != addr_q);
  end

  // State registers; reset beats a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q  <= '0;
      addr_q <= '0;
      upd_q  <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      addr_q <= addr_d;
      upd_q  <= upd_d;
    end
  end

  // Read mux: absent entries and unmapped addresses read as zero.
  always_comb begin
    CSRPReadValM = '0;
    for (int i = 0; i < NE; i++) begin
      if (i < PMP_ENTRIES) begin
        if (cfg_hit && !illegal && (cfg_n == 4'((i / BPR) * (BPR / 4))))
          CSRPReadValM[8*(i % BPR) +: 8] = cfg_q[i];
        if (addr_hit && (addr_n == 6'(i)))
          CSRPReadValM = XLEN'(addr_rd[i]);
      end
    end
  end

  assign PMPCFG_ARRAY_REGW  = cfg_q;
  assign PMPADDR_ARRAY_REGW = addr_q;
  assign IllegalPMPAccessM  = illegal;
  assign PMPUpdatedM        = upd_q;

endmodule

// File: tb/tb_pmp_csr_file.sv
// Bench for pmp_csr_file (default parameters: 16 entries, XLEN 64, PA 56, G 2).
module tb_pmp_csr_file;

  localparam int G = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              StallW = 1'b0;
  logic              CSRWriteM = 1'b0;
  logic              CSRReadM = 1'b0;
  logic [11:0]       CSRAdrM = '0;
  logic [63:0]       CSRWriteValM = '0;
  logic [15:0][7:0]  cfg_arr;
  logic [15:0][53:0] addr_arr;
  logic [63:0]       CSRPReadValM;
  logic              IllegalPMPAccessM;
  logic              PMPUpdatedM;

  int checks = 0;
  int errors = 0;

  pmp_csr_file dut (
    .clk                (clk),
    .reset              (reset),
    .StallW             (StallW),
    .CSRWriteM          (CSRWriteM),
    .CSRReadM           (CSRReadM),
    .CSRAdrM            (CSRAdrM),
    .CSRWriteValM       (CSRWriteValM),
    .PMPCFG_ARRAY_REGW  (cfg_arr),
    .PMPADDR_ARRAY_REGW (addr_arr),
    .CSRPReadValM       (CSRPReadValM),
    .IllegalPMPAccessM  (IllegalPMPAccessM),
    .PMPUpdatedM        (PMPUpdatedM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive at negedge, sample combinational outputs, then the pulse after the edge.
  task automatic op(input logic rst, input logic wr, input logic rd, input logic stall,
                    input logic [11:0] a, input logic [63:0] d,
                    output logic ill, output logic [63:0] rdata, output logic upd);
    @(negedge clk);
    reset = rst; CSRWriteM = wr; CSRReadM = rd; StallW = stall;
    CSRAdrM = a; CSRWriteValM = d;
    #1 ill = IllegalPMPAccessM; rdata = CSRPReadValM;
    @(posedge clk);
    #1 upd = PMPUpdatedM;
    reset = 1'b0; CSRWriteM = 1'b0; CSRReadM = 1'b0; StallW = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0]  m_cfg  [16];
  logic [53:0] m_addr [16];

  function automatic void m_reset();
    for (int e = 0; e < 16; e++) begin m_cfg[e] = 8'h00; m_addr[e] = '0; end
  endfunction

  function automatic bit is_cfg(input logic [11:0] a);
    return a >= 12'h3A0 && a <= 12'h3AF;
  endfunction

  function automatic bit is_addr(input logic [11:0] a);
    return a >= 12'h3B0 && a <= 12'h3EF;
  endfunction

  // Applies a committed write; returns 1 when any stored bit changed.
  function automatic bit m_write(input logic [11:0] a, input logic [63:0] d);
    bit changed = 0;
    if (is_cfg(a)) begin
      int n = int'(a) - 'h3A0;
      if (n % 2 == 1) return 0;
      for (int b = 0; b < 8; b++) begin
        int e = 4 * n + b;
        logic [7:0] nb = d[8*b +: 8];
        if (e >= 16 || m_cfg[e][7]) continue;
        nb = nb & 8'h9F;
        if (nb[1] && !nb[0]) nb[1] = 1'b0;
`ifdef PMP_G_EN
        if (nb[4:3] == 2'b10) nb[4:3] = m_cfg[e][4:3];
`endif
        if (nb != m_cfg[e]) changed = 1;
        m_cfg[e] = nb;
      end
    end else if (is_addr(a)) begin
      int i = int'(a) - 'h3B0;
      bit locked;
      if (i >= 16) return 0;
      locked = m_cfg[i][7] || (i < 15 && m_cfg[i+1][7] && m_cfg[i+1][4:3] == 2'b01);
      if (!locked) begin
        if (m_addr[i] != d[53:0]) changed = 1;
        m_addr[i] = d[53:0];
      end
    end
    return changed;
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a);
    logic [63:0] r = '0;
    if (is_cfg(a)) begin
      int n = int'(a) - 'h3A0;
      if (n % 2 == 0)
        for (int b = 0; b < 8; b++)
          if (4 * n + b < 16) r[8*b +: 8] = m_cfg[4*n+b];
    end else if (is_addr(a)) begin
      int i = int'(a) - 'h3B0;
      if (i < 16) begin
        r = {10'd0, m_addr[i]};
`ifdef PMP_G_EN
        if (m_cfg[i][4:3] == 2'b11) r = r | ((64'd1 << (G - 1)) - 1);
        else if (m_cfg[i][4:3] != 2'b10) r = r & ~((64'd1 << G) - 1);
`endif
      end
    end
    return r;
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    string       name;
    logic [11:0] wa;
    logic [63:0] wd;
    logic [11:0] ra;
    logic [63:0] exp_rd;
    logic        exp_ill;
    logic        exp_upd;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic ill, upd;
    logic [63:0] rd;

    tbl.push_back(vec_t'{"cfg0_warl_lock",   12'h3A0, 64'h1F8A, 12'h3A0, 64'h1F88, 1'b0, 1'b1});
    tbl.push_back(vec_t'{"cfg1_illegal",     12'h3A1, 64'hFF,   12'h3A0, 64'h1F88, 1'b1, 1'b0});
    tbl.push_back(vec_t'{"cfg0_locked_byte", 12'h3A0, 64'h0,    12'h3A0, 64'h0088, 1'b0, 1'b1});
    tbl.push_back(vec_t'{"cfg0_e1_tor_lock", 12'h3A0, 64'h8900, 12'h3A0, 64'h8988, 1'b0, 1'b1});
    tbl.push_back(vec_t'{"addr0_locked",     12'h3B0, 64'h1234, 12'h3B0, 64'h0,    1'b0, 1'b0});
    tbl.push_back(vec_t'{"addr2_write",      12'h3B2, 64'h1234, 12'h3B2, 64'h1234, 1'b0, 1'b1});
    tbl.push_back(vec_t'{"addr2_nochange",   12'h3B2, 64'h1234, 12'h3B2, 64'h1234, 1'b0, 1'b0});
    tbl.push_back(vec_t'{"cfg2_e9_lock",     12'h3A2, 64'h8900, 12'h3A2, 64'h8900, 1'b0, 1'b1});
    tbl.push_back(vec_t'{"addr8_tor_locked", 12'h3B8, 64'h1234, 12'h3B8, 64'h0,    1'b0, 1'b0});
    tbl.push_back(vec_t'{"addr9_l_locked",   12'h3B9, 64'h1234, 12'h3B9, 64'h0,    1'b0, 1'b0});
    tbl.push_back(vec_t'{"addr10_write",     12'h3BA, 64'h1234, 12'h3BA, 64'h1234, 1'b0, 1'b1});
    tbl.push_back(vec_t'{"addr15_trunc",     12'h3BF, 64'hFFFF_FFFF_FFFF_FFFC, 12'h3BF,
                         64'h003F_FFFF_FFFF_FFFC, 1'b0, 1'b1});
    tbl.push_back(vec_t'{"addr16_absent",    12'h3C0, 64'h55,   12'h3C0, 64'h0,    1'b0, 1'b0});
    tbl.push_back(vec_t'{"cfg4_absent",      12'h3A4, 64'hFF,   12'h3A4, 64'h0,    1'b0, 1'b0});
    tbl.push_back(vec_t'{"unmapped",         12'h300, 64'hFF,   12'h300, 64'h0,    1'b0, 1'b0});
    tbl.push_back(vec_t'{"cfg2_reserved",    12'h3A2, 64'h67,   12'h3A2, 64'h8907, 1'b0, 1'b1});
`ifdef PMP_G_EN
    tbl.push_back(vec_t'{"cfg2_na4",         12'h3A2, 64'h0010_0007, 12'h3A2, 64'h0000_8907, 1'b0, 1'b0});
`else
    tbl.push_back(vec_t'{"cfg2_na4",         12'h3A2, 64'h0010_0007, 12'h3A2, 64'h0010_8907, 1'b0, 1'b1});
`endif

    // Reset state.
    op(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 64'h0, ill, rd, upd);
    op(1'b0, 1'b0, 1'b1, 1'b0, 12'h3A0, 64'h0, ill, rd, upd);
    chk("reset_cfg0", rd, 64'h0);
    chk("reset_upd", {63'd0, upd}, 64'h0);
    op(1'b0, 1'b0, 1'b1, 1'b0, 12'h3B0, 64'h0, ill, rd, upd);
    chk("reset_addr0", rd, 64'h0);

    foreach (tbl[k]) begin
      op(1'b0, 1'b1, 1'b0, 1'b0, tbl[k].wa, tbl[k].wd, ill, rd, upd);
      chk({tbl[k].name, "_ill"}, {63'd0, ill}, {63'd0, tbl[k].exp_ill});
      chk({tbl[k].name, "_upd"}, {63'd0, upd}, {63'd0, tbl[k].exp_upd});
      op(1'b0, 1'b0, 1'b1, 1'b0, tbl[k].ra, 64'h0, ill, rd, upd);
      chk({tbl[k].name, "_rd"}, rd, tbl[k].exp_rd);
    end

    // Stalled write commits nothing.
    op(1'b0, 1'b1, 1'b0, 1'b1, 12'h3B3, 64'h55, ill, rd, upd);
    chk("stall_upd", {63'd0, upd}, 64'h0);
    op(1'b0, 1'b0, 1'b1, 1'b0, 12'h3B3, 64'h0, ill, rd, upd);
    chk("stall_rd", rd, 64'h0);

    // Back-to-back changing writes give back-to-back pulses, then it drops.
    op(1'b0, 1'b1, 1'b0, 1'b0, 12'h3B5, 64'h1, ill, rd, upd);
    chk("b2b_upd1", {63'd0, upd}, 64'h1);
    op(1'b0, 1'b1, 1'b0, 1'b0, 12'h3B5, 64'h2, ill, rd, upd);
    chk("b2b_upd2", {63'd0, upd}, 64'h1);
    op(1'b0, 1'b0, 1'b1, 1'b0, 12'h3B5, 64'h0, ill, rd, upd);
    chk("b2b_idle_upd", {63'd0, upd}, 64'h0);
    chk("b2b_rd", rd, 64'h2);

    // Read of odd pmpcfg is illegal.
    op(1'b0, 1'b0, 1'b1, 1'b0, 12'h3A3, 64'h0, ill, rd, upd);
    chk("rd_cfg3_ill", {63'd0, ill}, 64'h1);
    chk("rd_cfg3_data", rd, 64'h0);

    // Reset wins over a same-cycle write.
    op(1'b1, 1'b1, 1'b0, 1'b0, 12'h3B6, 64'h77, ill, rd, upd);
    chk("rstwr_upd", {63'd0, upd}, 64'h0);
    op(1'b0, 1'b0, 1'b1, 1'b0, 12'h3B6, 64'h0, ill, rd, upd);
    chk("rstwr_addr6", rd, 64'h0);
    op(1'b0, 1'b0, 1'b1, 1'b0, 12'h3A0, 64'h0, ill, rd, upd);
    chk("rstwr_cfg0", rd, 64'h0);

`ifdef PMP_G_EN
    // Granularity read masking on entry 3 (G=2).
    op(1'b0, 1'b1, 1'b0, 1'b0, 12'h3A0, 64'h1800_0000, ill, rd, upd);
    chk("g_cfg_napot_upd", {63'd0, upd}, 64'h1);
    op(1'b0, 1'b1, 1'b0, 1'b0, 12'h3B3, 64'h1000, ill, rd, upd);
    op(1'b0, 1'b0, 1'b1, 1'b0, 12'h3B3, 64'h0, ill, rd, upd);
    chk("g_napot_rd", rd, 64'h1001);
    op(1'b0, 1'b1, 1'b0, 1'b0, 12'h3A0, 64'h0800_0000, ill, rd, upd);
    op(1'b0, 1'b0, 1'b1, 1'b0, 12'h3B3, 64'h0, ill, rd, upd);
    chk("g_tor_rd", rd, 64'h1000);
    chk("g_stored", {10'd0, addr_arr[3]}, 64'h1000);
    op(1'b0, 1'b1, 1'b0, 1'b0, 12'h3A0, 64'h1700_0000, ill, rd, upd);
    op(1'b0, 1'b0, 1'b1, 1'b0, 12'h3A0, 64'h0, ill, rd, upd);
    chk("g_na4_keep", rd, 64'h0F00_0000);
`endif

    // Randomised traffic against the reference model.
    op(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 64'h0, ill, rd, upd);
    m_reset();
    for (int n = 0; n < 600; n++) begin
      logic [11:0] a;
      logic [63:0] d, exp_rd;
      logic wr, rdq, stall, rst, exp_ill, exp_upd;
      int sel = $urandom_range(0, 9);
      a = (sel < 4) ? 12'h3A0 + 12'($urandom_range(0, 15)) :
          (sel < 8) ? 12'h3B0 + 12'($urandom_range(0, 19)) :
          (sel < 9) ? 12'h3B0 + 12'($urandom_range(0, 63)) : 12'($urandom);
      for (int b = 0; b < 8; b++)
        d[8*b +: 8] = {($urandom_range(0, 7) == 0), 7'($urandom)};
      if (sel >= 4 && $urandom_range(0, 1) == 1) d = {$urandom, $urandom};
      wr    = 1'($urandom_range(0, 1));
      rdq   = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 5) == 0);
      rst   = (n % 75 == 74);
      exp_ill = is_cfg(a) && a[0] && (wr || rdq);
      exp_rd  = m_read(a);
      if (rst) begin
        m_reset();
        exp_upd = 1'b0;
      end else if (wr && !stall && !exp_ill) exp_upd = m_write(a, d);
      else exp_upd = 1'b0;
      op(rst, wr, rdq, stall, a, d, ill, rd, upd);
      chk("rnd_ill", {63'd0, ill}, {63'd0, exp_ill});
      if (rdq) chk("rnd_rd", rd, exp_rd);
      chk("rnd_upd", {63'd0, upd}, {63'd0, exp_upd});
      for (int e = 0; e < 16; e++) begin
        if (cfg_arr[e] !== m_cfg[e]) chk("rnd_cfg_arr", {56'd0, cfg_arr[e]}, {56'd0, m_cfg[e]});
        if (addr_arr[e] !== m_addr[e]) chk("rnd_addr_arr", {10'd0, addr_arr[e]}, {10'd0, m_addr[e]});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
